// File: rtl/rc4_pkg.sv
// rc4_pkg: definitions shared by the RC4 encryptor and the key-search decrypt cores.
//   rc4_enc_state_t : every FSM state of the encryptor. The KSA sub-module uses the
//                     INIT/K_* subset, and the parent uses the P_* subset.
//   RC4_S_SIZE      : number of entries in the S permutation.
//   RC4_KEY_BYTES   : secret key length in bytes (24-bit key).
//   rc4_key_byte()  : key byte used at index i. Byte 0 is the MSB of the key.
package rc4_pkg;

    localparam int RC4_S_SIZE    = 256;
    localparam int RC4_KEY_BYTES = 3;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_INIT,
        ST_K_RD_SI,
        ST_K_WT_SI,
        ST_K_RD_SJ,
        ST_K_WT_SJ,
        ST_K_WR_I,
        ST_K_WR_J,
        ST_KSA,        // parent waits while the KSA sub-module owns the S port
        ST_P_RD_SI,
        ST_P_WT_SI,
        ST_P_RD_SJ,
        ST_P_WT_SJ,
        ST_P_WR_I,
        ST_P_WR_J,
        ST_P_RD_F,
        ST_P_WT_F,
        ST_P_WR_CT,
        ST_DONE
    } rc4_enc_state_t;

    function automatic logic [7:0] rc4_key_byte(input logic [23:0] key, input logic [7:0] i);
        logic [7:0] sel;
        sel = i % 8'(RC4_KEY_BYTES);
        case (sel)
            8'd0:    rc4_key_byte = key[23:16];
            8'd1:    rc4_key_byte = key[15:8];
            default: rc4_key_byte = key[7:0];
        endcase
    endfunction

endpackage

// File: rtl/rc4_encryptor_if.sv
// rc4_encryptor_if: groups the control handshake and the three memory ports.
//   Control: start/key in; busy, done, ct_checksum out; dbg_state shows the active FSM state.
//   S RAM  : s_address/s_data/s_wren out, s_q in (synchronous read, one-cycle latency).
//   PT ROM : pt_address out, pt_q in (synchronous read).
//   CT RAM : ct_address/ct_data/ct_wren out.
// Handshake: start is a request. It is accepted on a rising edge only while busy is low
// (the encryptor is in IDLE). key is sampled on that same edge. busy stays high from the
// next cycle through the done cycle. done is a one-cycle completion pulse. A start that
// arrives while busy is high is dropped and is not queued.
// modport master: the encryptor side. modport slave: the host and memories side.
interface rc4_encryptor_if;
    import rc4_pkg::*;

    logic           start;
    logic [23:0]    key;
    logic           busy;
    logic           done;
    logic [7:0]     ct_checksum;
    logic [7:0]     s_address;
    logic [7:0]     s_data;
    logic           s_wren;
    logic [7:0]     s_q;
    logic [4:0]     pt_address;
    logic [7:0]     pt_q;
    logic [4:0]     ct_address;
    logic [7:0]     ct_data;
    logic           ct_wren;
    rc4_enc_state_t dbg_state;

    modport master (
        input  start, key, s_q, pt_q,
        output busy, done, ct_checksum, s_address, s_data, s_wren,
               pt_address, ct_address, ct_data, ct_wren, dbg_state
    );

    modport slave (
        output start, key, s_q, pt_q,
        input  busy, done, ct_checksum, s_address, s_data, s_wren,
               pt_address, ct_address, ct_data, ct_wren, dbg_state
    );

endinterface

// File: rtl/rc4_ksa.sv
// rc4_ksa: the S initialisation (s[i]=i) followed by the RC4 key schedule.
//   clock, reset_n : clock and asynchronous active-low reset.
//   start          : begins INIT on the same edge. key is latched on that edge.
//   done           : combinational, high during the final K_WR_J cycle (i=255). This
//                    lets the parent step straight into the PRGA without a gap cycle.
//   s_*            : S RAM port. It is only meaningful while this block is out of IDLE.
//   state          : current state, for debug visibility.
import rc4_pkg::*;

module rc4_ksa (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [23:0]    key,
    output logic           done,
    output logic [7:0]     s_address,
    output logic [7:0]     s_data,
    output logic           s_wren,
    input  logic [7:0]     s_q,
    output rc4_enc_state_t state
);

    localparam logic [7:0] LAST_I = 8'(RC4_S_SIZE - 1);

    rc4_enc_state_t state_nx;
    logic [23:0]    key_r;
    logic [7:0]     i, j, si, sj;
    logic [7:0]     j_new;

    // The new j drives the read address in the same cycle it is registered.
    assign j_new = j + si + rc4_key_byte(key_r, i);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            key_r <= 24'h0;
            i     <= 8'h0;
            j     <= 8'h0;
            si    <= 8'h0;
            sj    <= 8'h0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (start) begin
                    key_r <= key;
                    i     <= 8'h0;
                    j     <= 8'h0;
                end
                ST_INIT:    i  <= i + 8'd1;
                ST_K_WT_SI: si <= s_q;
                ST_K_RD_SJ: j  <= j_new;
                ST_K_WT_SJ: sj <= s_q;
                ST_K_WR_J:  i  <= i + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start) state_nx = ST_INIT;
            ST_INIT:    if (i == LAST_I) state_nx = ST_K_RD_SI;
            ST_K_RD_SI: state_nx = ST_K_WT_SI;
            ST_K_WT_SI: state_nx = ST_K_RD_SJ;
            ST_K_RD_SJ: state_nx = ST_K_WT_SJ;
            ST_K_WT_SJ: state_nx = ST_K_WR_I;
            ST_K_WR_I:  state_nx = ST_K_WR_J;
            ST_K_WR_J:  state_nx = (i == LAST_I) ? ST_IDLE : ST_K_RD_SI;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        s_address = 8'h0;
        s_data    = 8'h0;
        s_wren    = 1'b0;
        case (state)
            ST_INIT: begin
                s_address = i;
                s_data    = i;
                s_wren    = 1'b1;
            end
            ST_K_RD_SI: s_address = i;
            ST_K_RD_SJ: s_address = j_new;
            ST_K_WR_I: begin
                s_address = i;
                s_data    = sj;
                s_wren    = 1'b1;
            end
            // When i==j this write lands last and stores si, which equals sj anyway.
            ST_K_WR_J: begin
                s_address = j;
                s_data    = si;
                s_wren    = 1'b1;
            end
            default: ;
        endcase
    end

    assign done = (state == ST_K_WR_J) && (i == LAST_I);

endmodule

// File: rtl/rc4_encryptor.sv
// rc4_encryptor: RC4 encryption of a MSG_LEN-byte plaintext ROM into a ciphertext RAM,
// using an external 256x8 S RAM as working memory.
//   MSG_LEN        : message length in bytes, 1..32.
//   clock, reset_n : single rising-edge clock and asynchronous active-low reset.
//   bus            : rc4_encryptor_if.master, which carries the start/key/busy/done
//                    handshake, ct_checksum, the S RAM, PT ROM and CT RAM ports, and
//                    dbg_state.
// The rc4_ksa sub-module runs INIT and the KSA. This module runs the PRGA and muxes the
// S port by phase.
// Optional feature: defining RC4_ENCRYPTOR_CHECKSUM_EN builds a running XOR of the
// ciphertext bytes on ct_checksum. Without it, ct_checksum is tied to 0.
import rc4_pkg::*;

module rc4_encryptor #(
    parameter int MSG_LEN = 32
) (
    input logic              clock,
    input logic              reset_n,
    rc4_encryptor_if.master  bus
);

    localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

    rc4_enc_state_t state, state_nx, ksa_state;
    logic [7:0]     i, j, si, sj, f, pt;
    logic [4:0]     k;
    logic           ksa_start, ksa_done, ksa_wren;
    logic [7:0]     ksa_addr, ksa_data;
    logic [7:0]     prga_addr, prga_data;
    logic           prga_wren;
    logic [7:0]     ct_byte;

    assign ksa_start = (state == ST_IDLE) && bus.start;
    assign ct_byte   = f ^ pt;

    rc4_ksa u_ksa (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (ksa_start),
        .key       (bus.key),
        .done      (ksa_done),
        .s_address (ksa_addr),
        .s_data    (ksa_data),
        .s_wren    (ksa_wren),
        .s_q       (bus.s_q),
        .state     (ksa_state)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            i     <= 8'h0;
            j     <= 8'h0;
            si    <= 8'h0;
            sj    <= 8'h0;
            f     <= 8'h0;
            pt    <= 8'h0;
            k     <= 5'h0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (bus.start) begin
                    i <= 8'h0;
                    j <= 8'h0;
                    k <= 5'h0;
                end
                ST_P_RD_SI: i  <= i + 8'd1;
                ST_P_WT_SI: si <= bus.s_q;
                ST_P_RD_SJ: j  <= j + si;
                ST_P_WT_SJ: sj <= bus.s_q;
                ST_P_WT_F: begin
                    f  <= bus.s_q;
                    pt <= bus.pt_q;
                end
                ST_P_WR_CT: k <= k + 5'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (bus.start) state_nx = ST_KSA;
            ST_KSA:     if (ksa_done) state_nx = ST_P_RD_SI;
            ST_P_RD_SI: state_nx = ST_P_WT_SI;
            ST_P_WT_SI: state_nx = ST_P_RD_SJ;
            ST_P_RD_SJ: state_nx = ST_P_WT_SJ;
            ST_P_WT_SJ: state_nx = ST_P_WR_I;
            ST_P_WR_I:  state_nx = ST_P_WR_J;
            ST_P_WR_J:  state_nx = ST_P_RD_F;
            ST_P_RD_F:  state_nx = ST_P_WT_F;
            ST_P_WT_F:  state_nx = ST_P_WR_CT;
            ST_P_WR_CT: state_nx = (k == LAST_K) ? ST_DONE : ST_P_RD_SI;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // PRGA side of the S port. The read addresses use the updated i/j combinationally,
    // because those registers only take their new values at the end of the read cycle.
    always_comb begin
        prga_addr = 8'h0;
        prga_data = 8'h0;
        prga_wren = 1'b0;
        case (state)
            ST_P_RD_SI: prga_addr = i + 8'd1;
            ST_P_RD_SJ: prga_addr = j + si;
            ST_P_WR_I: begin
                prga_addr = i;
                prga_data = sj;
                prga_wren = 1'b1;
            end
            ST_P_WR_J: begin
                prga_addr = j;
                prga_data = si;
                prga_wren = 1'b1;
            end
            ST_P_RD_F: prga_addr = si + sj;
            default: ;
        endcase
    end

    assign bus.s_address  = (state == ST_KSA) ? ksa_addr : prga_addr;
    assign bus.s_data     = (state == ST_KSA) ? ksa_data : prga_data;
    assign bus.s_wren     = (state == ST_KSA) ? ksa_wren : prga_wren;
    assign bus.pt_address = (state == ST_P_RD_F)  ? k : 5'h0;
    assign bus.ct_address = (state == ST_P_WR_CT) ? k : 5'h0;
    assign bus.ct_data    = (state == ST_P_WR_CT) ? ct_byte : 8'h0;
    assign bus.ct_wren    = (state == ST_P_WR_CT);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.dbg_state  = (state == ST_KSA) ? ksa_state : state;

`ifdef RC4_ENCRYPTOR_CHECKSUM_EN
    logic [7:0] checksum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= 8'h0;
        end else if (ksa_start) begin
            checksum <= 8'h0;
        end else if (state == ST_P_WR_CT) begin
            checksum <= checksum ^ ct_byte;
        end
    end

    assign bus.ct_checksum = checksum;
`else
    assign bus.ct_checksum = 8'h0;
`endif

endmodule
